// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready operand and result handshakes.
// Single-cycle ops (add/sub/logic/shift/slt) produce their result the
// cycle after acceptance. Optional iterative shift-add multiply is built
// only when the ALU_MUL_EN macro is defined; without it opcode 0001 is
// reported as illegal and the FSM reduces to IDLE/DONE.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge; ready may depend combinationally on the
// opposite side's signals (in_ready looks at out_ready) but valid never
// depends on ready. Once out_valid rises, alu_out/alu_overflow/alu_illegal
// stay frozen until the result is taken.
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  alu_overflow,
    output logic                  alu_illegal
);

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_AND = 4'b1010;
    localparam logic [3:0] OP_OR  = 4'b1011;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_NOR = 4'b1101;
    localparam logic [3:0] OP_SLL = 4'b1110;
    localparam logic [3:0] OP_SRL = 4'b1111;
    localparam logic [3:0] OP_SRA = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b0011;

    localparam int MSB = DATA_WIDTH - 1;

    // State encoding is fixed so checkers can bind to 'state' directly.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MUL_EN
        MUL  = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t state;

    logic                  accept;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] res;
    logic                  res_ovf;
    logic                  res_ill;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0001;

    // Multiply datapath: 2W accumulator so the high half yields overflow.
    logic [2*DATA_WIDTH-1:0] mul_acc;
    logic [2*DATA_WIDTH-1:0] mul_mcand;
    logic [DATA_WIDTH-1:0]   mul_mplier;
    logic [SHAMT_W-1:0]      mul_cnt;
    logic [2*DATA_WIDTH-1:0] mul_acc_next;

    // Next accumulator value after the current partial-product step.
    always_comb begin
        mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    end
`endif

    // New work is taken only from IDLE, or from DONE while the result leaves.
    assign in_ready = alu_enable & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    assign sum   = src1 + src2;
    assign diff  = src1 - src2;
    assign shamt = src2[SHAMT_W-1:0];

    // Single-cycle result, overflow and illegal flag for the presented opcode.
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_ill = 1'b0;
        case (alu_op)
            OP_ADD: begin
                res     = sum;
                res_ovf = (src1[MSB] == src2[MSB]) && (sum[MSB] != src1[MSB]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (src1[MSB] != src2[MSB]) && (diff[MSB] != src1[MSB]);
            end
            OP_AND: res = src1 & src2;
            OP_OR:  res = src1 | src2;
            OP_XOR: res = src1 ^ src2;
            OP_NOR: res = ~(src1 | src2);
            OP_SLL: res = src1 << shamt;
            OP_SRL: res = src1 >> shamt;
            OP_SRA: res = $unsigned($signed(src1) >>> shamt);
            OP_SLT: res[0] = ($signed(src1) < $signed(src2));
            default: res_ill = 1'b1;
        endcase
    end

    // Control FSM with registered result, flags and multiply datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            alu_out      <= '0;
            alu_overflow <= 1'b0;
            alu_illegal  <= 1'b0;
`ifdef ALU_MUL_EN
            mul_acc      <= '0;
            mul_mcand    <= '0;
            mul_mplier   <= '0;
            mul_cnt      <= '0;
`endif
        end else begin
            case (state)
`ifdef ALU_MUL_EN
                MUL: begin
                    // One partial-product step per cycle; the last step also
                    // publishes the result so latency is DATA_WIDTH+1.
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 1'b1;
                    if (mul_cnt == {SHAMT_W{1'b1}}) begin
                        alu_out      <= mul_acc_next[DATA_WIDTH-1:0];
                        alu_overflow <= |mul_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
                        alu_illegal  <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
`endif
                default: begin
                    // IDLE and DONE share the load path; accept already
                    // implies out_ready when the current state is DONE.
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (alu_op == OP_MUL) begin
                            mul_acc    <= '0;
                            mul_mcand  <= {{DATA_WIDTH{1'b0}}, src1};
                            mul_mplier <= src2;
                            mul_cnt    <= '0;
                            out_valid  <= 1'b0;
                            state      <= MUL;
                        end else
`endif
                        begin
                            alu_out      <= res;
                            alu_overflow <= res_ovf;
                            alu_illegal  <= res_ill;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq with hand-computed expected values.
// Multiply checks are compiled in when ALU_MUL_EN is defined; otherwise
// opcode 0001 is checked as illegal.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         alu_enable;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         alu_overflow;
    logic         alu_illegal;

    int n_vec;
    int n_err;

    logic [W-1:0] exp_q[$];

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_enable   (alu_enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .src1         (src1),
        .src2         (src2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .alu_illegal  (alu_illegal)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        src1     = a;
        src2     = b;
    endtask

    // Presents one op, checks it is accepted and returns just after the accept edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(op, a, b);
        check("send_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Single-op vector table: op, src1, src2, result, overflow, illegal.
    localparam int NV = 15;
    logic [3:0]   v_op  [NV] = '{4'b1000, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                                 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0010,
                                 4'b0011, 4'b0011, 4'b0000, 4'b0100, 4'b0111};
    logic [W-1:0] v_a   [NV] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000001, 32'h80000000, 32'h80000000,
                                 32'hFFFFFFFF, 32'h00000001, 32'h00001234, 32'h00000005, 32'hFFFFFFFF};
    logic [W-1:0] v_b   [NV] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'hFF00FF00, 32'hFF00FF00,
                                 32'hFF00FF00, 32'hFF00FF00, 32'h00000022, 32'h0000001F, 32'h0000001F,
                                 32'h00000001, 32'hFFFFFFFF, 32'h00005678, 32'h00000006, 32'h00000001};
    logic [W-1:0] v_res [NV] = '{32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'hF000F000, 32'hFFF0FFF0,
                                 32'h0FF00FF0, 32'h000F000F, 32'h00000004, 32'h00000001, 32'hFFFFFFFF,
                                 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    logic         v_ovf [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         v_ill [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Back-to-back stream: SUB, SRA, SRL, SLL.
    logic [3:0]   b_op  [4] = '{4'b1001, 4'b0010, 4'b1111, 4'b1110};
    logic [W-1:0] b_a   [4] = '{32'hAF3CFF00, 32'hFF0000FF, 32'hFF0000FF, 32'hFF0000FF};
    logic [W-1:0] b_b   [4] = '{32'h50C3FF00, 32'h00000002, 32'h00000002, 32'h00000002};
    logic [W-1:0] b_res [4] = '{32'h5E790000, 32'hFFC0003F, 32'h3FC0003F, 32'hFC0003FC};
    logic         b_ovf [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Directed stimulus sequence.
    initial begin
        int lat;
        int seen;
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        alu_enable = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        alu_op     = 4'b0000;
        src1       = '0;
        src2       = '0;

        // Reset values.
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu_out", 64'(alu_out), 64'd0);
        check("rst_ovf", 64'(alu_overflow), 64'd0);
        check("rst_ill", 64'(alu_illegal), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Single ops, one at a time, result the cycle after accept.
        for (int i = 0; i < NV; i++) begin
            send(v_op[i], v_a[i], v_b[i]);
            check("op_out_valid", 64'(out_valid), 64'd1);
            check("op_alu_out", 64'(alu_out), 64'(v_res[i]));
            check("op_ovf", 64'(alu_overflow), 64'(v_ovf[i]));
            check("op_ill", 64'(alu_illegal), 64'(v_ill[i]));
            tick();
            check("op_drain", 64'(out_valid), 64'd0);
        end

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                check("b2b_out_valid", 64'(out_valid), 64'd1);
                check("b2b_alu_out", 64'(alu_out), 64'(exp_q.pop_front()));
                check("b2b_ovf", 64'(alu_overflow), 64'(b_ovf[i-1]));
            end
            if (i < 4) begin
                drive(b_op[i], b_a[i], b_b[i]);
                check("b2b_in_ready", 64'(in_ready), 64'd1);
                exp_q.push_back(b_res[i]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("b2b_drain", 64'(out_valid), 64'd0);

        // Backpressure: result held, pending op not taken until out_ready.
        out_ready = 1'b0;
        send(4'b1000, 32'd3, 32'd4);
        drive(4'b1100, 32'h000000F0, 32'h0000000F);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_alu_out", 64'(alu_out), 64'h7);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_out", 64'(alu_out), 64'hFF);
        tick();
        check("bp_drain", 64'(out_valid), 64'd0);

        // alu_enable low blocks acceptance.
        alu_enable = 1'b0;
        drive(4'b1000, 32'd1, 32'd1);
        #1;
        check("en_in_ready", 64'(in_ready), 64'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("en_no_result", 64'(seen), 64'd0);
        in_valid   = 1'b0;
        alu_enable = 1'b1;
        tick();

`ifdef ALU_MUL_EN
        // Multiply latency and results.
        send(4'b0001, 32'h00012345, 32'h00000010);
        drive(4'b1000, 32'd1, 32'd2);
        #1;
        check("mul_busy_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("mul1_latency", 64'(lat), 64'd33);
        check("mul1_out", 64'(alu_out), 64'h00123450);
        check("mul1_ovf", 64'(alu_overflow), 64'd0);
        tick();

        send(4'b0001, 32'h00010000, 32'h00010000);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("mul2_latency", 64'(lat), 64'd33);
        check("mul2_out", 64'(alu_out), 64'h0);
        check("mul2_ovf", 64'(alu_overflow), 64'd1);
        tick();

        // Leave a nonzero result, then reset part-way into a multiply.
        send(4'b1011, 32'h0000A5A5, 32'h00000000);
        tick();
        send(4'b0001, 32'h00012345, 32'h00000010);
        for (int i = 0; i < 9; i++) tick();
        check("rstmul_pre_out", 64'(alu_out), 64'h0000A5A5);
`else
        // Without the multiplier, opcode 0001 is illegal.
        send(4'b0001, 32'h00000003, 32'h00000004);
        check("mul_off_valid", 64'(out_valid), 64'd1);
        check("mul_off_ill", 64'(alu_illegal), 64'd1);
        check("mul_off_out", 64'(alu_out), 64'd0);
        tick();

        // Reset while a result is stalled by backpressure.
        out_ready = 1'b0;
        send(4'b1011, 32'h0000A5A5, 32'h00000000);
        tick();
        check("rst_pre_out", 64'(alu_out), 64'h0000A5A5);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_out", 64'(alu_out), 64'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_no_stale", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised successor to the combinational ALU. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake. Simple operations complete in 1 cycle. An iterative shift-add multiply takes DATA_WIDTH+1 cycles. The block sits between the register-file read stage and the writeback stage and tolerates writeback backpressure.

Parameters:
DATA_WIDTH, 32, operand/result width; must be a power of 2, at least 8.
SHAMT_W, $clog2(DATA_WIDTH), number of src2 LSBs used as the shift amount (derived; do not override).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
alu_enable  input  1  0 blocks new acceptance (in_ready forced 0); an in-flight operation still completes.
in_valid  input  1  operand/opcode valid.
in_ready  output  1  block can accept this cycle.
alu_op  input  4  opcode.
src1  input  DATA_WIDTH  operand 1.
src2  input  DATA_WIDTH  operand 2.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
alu_out  output  DATA_WIDTH  registered result.
alu_overflow  output  1  registered overflow flag.
alu_illegal  output  1  registered flag: opcode was unsupported.

Behaviour:
- Opcode map:
  - 1000 ADD, 1001 SUB, 1010 AND, 1011 OR, 1100 XOR, 1101 NOR.
  - 1110 SLL, 1111 SRL, 0010 SRA, 0011 SLT (signed; result 1 or 0).
  - 0001 MUL (unsigned, low DATA_WIDTH bits).
  - All other codes are illegal: alu_out=0, alu_overflow=0, alu_illegal=1, 1-cycle latency.
- Overflow rules:
  - ADD/SUB: signed overflow (operand signs and result sign rule).
  - MUL: 1 if any bit of the full 2*DATA_WIDTH product above bit DATA_WIDTH-1 is set.
  - All other ops: 0.
- Shifts use src2[SHAMT_W-1:0]; upper src2 bits are ignored.
- FSM states are IDLE, MUL, DONE. Reset enters IDLE.
  - Reset values: out_valid=0, alu_out=0, alu_overflow=0, alu_illegal=0, multiply accumulator and counter cleared.
- Accept condition: in_valid & in_ready.
  - in_ready = alu_enable & (state==IDLE | (state==DONE & out_ready)).
  - This gives full throughput of 1 op/cycle for single-cycle ops when out_ready is held high.
- On accept of a non-MUL op: result is registered and the state becomes DONE. out_valid=1 the cycle after accept.
- On accept of MUL: operands are latched, counter=0, state becomes MUL.
  - One partial-product step per cycle for DATA_WIDTH cycles.
  - Then DONE. out_valid asserts exactly DATA_WIDTH+1 cycles after accept.
- In DONE:
  - alu_out, alu_overflow and alu_illegal stay stable until out_valid & out_ready.
  - On that handshake, with a simultaneous accept, the next op is loaded (DONE→DONE or DONE→MUL).
  - Otherwise the state returns to IDLE and out_valid goes to 0.
- in_valid while in MUL or while DONE is stalled is ignored (in_ready=0). Inputs are not sampled.
- alu_enable falling while in MUL: the multiply completes normally. Afterwards no new accept until alu_enable=1.
- rst mid-operation: the operation is discarded immediately. Outputs take their reset values asynchronously, and no result is produced after reset release.

Optional Feature:
ALU_MUL_EN
- Defined: MUL opcode 0001 is supported as above, with the MUL state, accumulator and counter present.
- Undefined: 0001 is treated as illegal (1-cycle latency, alu_illegal=1, alu_out=0). The MUL state and datapath are not built, and the FSM reduces to IDLE/DONE.

Test Plan:
1. ADD src1=0x7FFFFFFF, src2=0x00000001, out_ready=1 -> next cycle out_valid=1, alu_out=0x80000000, alu_overflow=1.
2. Back-to-back with out_ready=1: SUB 0xAF3CFF00-0x50C3FF00, then SRA 0xFF0000FF by 2, then SRL the same operands, then SLL the same operands.
   - Results on consecutive cycles: 0x5E790000 (ovf=1), 0xFFC0003F, 0x3FC0003F, 0xFC0003FC.
   - in_ready stays 1 throughout.
3. MUL (ALU_MUL_EN defined):
   - 0x00012345*0x00000010 -> out_valid exactly 33 cycles after accept, alu_out=0x00123450, ovf=0.
   - 0x00010000*0x00010000 -> alu_out=0x00000000, ovf=1.
4. Backpressure: ADD 3+4 with out_ready=0 for 5 cycles.
   - out_valid=1 and alu_out=0x00000007 held stable; in_ready=0; a pending in_valid op is not taken.
   - Op is accepted the cycle out_ready rises.
5. Illegal op 0x0 and alu_enable=0:
   - op 0000 -> alu_out=0, alu_illegal=1 after 1 cycle.
   - With alu_enable=0, in_valid=1 -> in_ready=0, no out_valid.
   - Without ALU_MUL_EN, op 0001 -> alu_illegal=1 after 1 cycle.
6. Reset mid-MUL: assert rst 10 cycles into a MUL -> out_valid=0, alu_out=0 immediately (asynchronous); after release, state is IDLE, in_ready=1, and no stale result appears.
